// File: rtl/pf_slot_tracker_pkg.sv
// pf_slot_tracker_pkg: FSM state and slot-index types shared by the slot tracker.
package pf_slot_tracker_pkg;
  localparam int PF_LOG_SLOTS = 2;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} pf_state_e;
  typedef logic [PF_LOG_SLOTS-1:0] pf_slot_idx_t;
endpackage

// File: rtl/pf_slot_tracker_ones_cnt.sv
// onesCnt: population count of a 2**LOG_VEC_SIZE-bit vector.
module onesCnt #(
  parameter int LOG_VEC_SIZE = 2
) (
  input  logic [(1<<LOG_VEC_SIZE)-1:0] i_vec,
  output logic [LOG_VEC_SIZE:0]        o_cnt
);
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < (1 << LOG_VEC_SIZE); i++) o_cnt = o_cnt + (LOG_VEC_SIZE+1)'(i_vec[i]);
  end
endmodule

// File: rtl/pf_slot_tracker.sv
// pf_slot_tracker: lowest-free slot allocator with release, throttle cap and drain sequencer.
module pf_slot_tracker
  import pf_slot_tracker_pkg::*;
#(
  parameter int  LOG_SLOTS = PF_LOG_SLOTS,
  localparam int SLOTS     = 1 << LOG_SLOTS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  output logic [LOG_SLOTS-1:0] alloc_idx,
  input  logic                 free_valid,
  input  logic [LOG_SLOTS-1:0] free_idx,
  input  logic [LOG_SLOTS:0]   max_inflight,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic [SLOTS-1:0]     slots_busy,
  output logic [LOG_SLOTS:0]   busy_cnt,
  output logic                 full,
  output logic                 empty,
  output logic                 err_double_free
);
  pf_state_e        r_state;
  logic             r_live;
  logic             w_grant, w_free_ok;
  logic [SLOTS-1:0] w_set, w_clr;
  onesCnt #(.LOG_VEC_SIZE(LOG_SLOTS)) u_cnt (.i_vec(slots_busy), .o_cnt(busy_cnt));
  assign full        = busy_cnt == (LOG_SLOTS+1)'(SLOTS);
  assign empty       = busy_cnt == '0;
  // r_live holds grants off for the first cycle after reset releases
  assign alloc_ready = r_live && r_state == RUN && !full && busy_cnt < max_inflight;
  assign flush_done  = r_state == DONE;
  always_comb begin
    alloc_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) if (!slots_busy[i]) alloc_idx = LOG_SLOTS'(i);
  end
  assign w_grant   = alloc_valid && alloc_ready;
  assign w_free_ok = free_valid && slots_busy[free_idx];
  assign w_set     = w_grant ? SLOTS'(1) << alloc_idx : '0;
  assign w_clr     = w_free_ok ? SLOTS'(1) << free_idx : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= RUN;
      r_live          <= 1'b0;
      slots_busy      <= '0;
      err_double_free <= 1'b0;
    end else begin
      r_live     <= 1'b1;
      slots_busy <= (slots_busy | w_set) & ~w_clr;
      if (free_valid && !slots_busy[free_idx]) err_double_free <= 1'b1;
      r_state <= r_state == RUN   ? (flush_req ? DRAIN : RUN) :
                 r_state == DRAIN ? (empty ? DONE : DRAIN) : RUN;
    end
  end
endmodule

// File: tb/tb_pf_slot_tracker.sv
// tb_pf_slot_tracker: directed vector table plus randomized run against a slot-set reference model.
module tb_pf_slot_tracker;
  logic       clk = 1'b0;
  logic       rst, alloc_valid, alloc_ready, free_valid, flush_req, flush_done;
  logic       full, empty, err_double_free;
  logic [1:0] alloc_idx, free_idx;
  logic [2:0] max_inflight, busy_cnt;
  logic [3:0] slots_busy;
  always #5 clk = ~clk;
  pf_slot_tracker #(.LOG_SLOTS(2)) dut (
    .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_idx(alloc_idx), .free_valid(free_valid), .free_idx(free_idx),
    .max_inflight(max_inflight), .flush_req(flush_req), .flush_done(flush_done),
    .slots_busy(slots_busy), .busy_cnt(busy_cnt), .full(full), .empty(empty),
    .err_double_free(err_double_free)
  );
  int n_pass = 0, n_chk = 0;
  bit m_busy[4];
  int m_mode;
  bit m_live, m_err;
  function automatic int m_cnt();
    int c = 0;
    foreach (m_busy[i]) c += int'(m_busy[i]);
    return c;
  endfunction
  function automatic int m_vec();
    int v = 0;
    foreach (m_busy[i]) if (m_busy[i]) v += (1 << i);
    return v;
  endfunction
  function automatic int m_first_free();
    for (int i = 0; i < 4; i++) if (!m_busy[i]) return i;
    return 0;
  endfunction
  function automatic bit m_ready(input int mx);
    return m_live && m_mode == 0 && m_cnt() < 4 && m_cnt() < mx;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask
  task automatic drive(input bit r, av, fv, input int fi, mx, input bit fl);
    @(negedge clk);
    rst = r; alloc_valid = av; free_valid = fv; free_idx = 2'(fi);
    max_inflight = 3'(mx); flush_req = fl;
    #1;
    chk("model.slots_busy", int'(slots_busy), m_vec());
    chk("model.busy_cnt", int'(busy_cnt), m_cnt());
    chk("model.full", int'(full), int'(m_cnt() == 4));
    chk("model.empty", int'(empty), int'(m_cnt() == 0));
    chk("model.alloc_ready", int'(alloc_ready), int'(m_ready(mx)));
    chk("model.flush_done", int'(flush_done), int'(m_mode == 2));
    chk("model.err", int'(err_double_free), int'(m_err));
    if (m_ready(mx) || m_cnt() == 4) chk("model.alloc_idx", int'(alloc_idx), m_first_free());
  endtask
  task automatic advance();
    bit grant;
    int gi, c;
    @(posedge clk);
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_mode = 0; m_live = 1'b0; m_err = 1'b0;
    end else begin
      c = m_cnt();
      grant = alloc_valid && m_ready(int'(max_inflight));
      gi = m_first_free();
      m_mode = (m_mode == 0) ? (flush_req ? 1 : 0) : (m_mode == 1) ? (c == 0 ? 2 : 1) : 0;
      if (free_valid && !m_busy[free_idx]) m_err = 1'b1;
      else if (free_valid) m_busy[free_idx] = 1'b0;
      if (grant) m_busy[gi] = 1'b1;
      m_live = 1'b1;
    end
  endtask
  typedef struct {
    bit r, av, fv; int fi, mx; bit fl;
    int e_busy; bit e_rdy, e_done, e_err;
  } vec_t;
  vec_t tv[$];
  initial begin
    rst = 1'b1; alloc_valid = 0; free_valid = 0; free_idx = 0; max_inflight = 3'd4; flush_req = 0;
    repeat (2) @(posedge clk);
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_mode = 0; m_live = 1'b0; m_err = 1'b0;
    //          r  av fv fi mx fl  busy     rdy done err
    tv.push_back('{1, 0, 0, 0, 4, 0, 4'b0000, 0, 0, 0});
    tv.push_back('{0, 1, 0, 0, 4, 0, 4'b0000, 0, 0, 0});
    tv.push_back('{0, 1, 0, 0, 4, 0, 4'b0000, 1, 0, 0});
    tv.push_back('{0, 1, 0, 0, 4, 0, 4'b0001, 1, 0, 0});
    tv.push_back('{0, 1, 0, 0, 4, 0, 4'b0011, 1, 0, 0});
    tv.push_back('{0, 1, 0, 0, 4, 0, 4'b0111, 1, 0, 0});
    tv.push_back('{0, 1, 1, 1, 4, 0, 4'b1111, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 4, 0, 4'b1101, 1, 0, 0});
    tv.push_back('{1, 0, 0, 0, 4, 0, 4'b1101, 1, 0, 0});
    tv.push_back('{0, 1, 0, 0, 2, 0, 4'b0000, 0, 0, 0});
    tv.push_back('{0, 1, 0, 0, 2, 0, 4'b0000, 1, 0, 0});
    tv.push_back('{0, 1, 0, 0, 2, 0, 4'b0001, 1, 0, 0});
    tv.push_back('{0, 1, 0, 0, 2, 0, 4'b0011, 0, 0, 0});
    tv.push_back('{0, 1, 1, 1, 4, 0, 4'b0011, 1, 0, 0});
    tv.push_back('{0, 0, 0, 0, 4, 1, 4'b0101, 1, 0, 0});
    tv.push_back('{0, 1, 1, 0, 4, 0, 4'b0101, 0, 0, 0});
    tv.push_back('{0, 1, 0, 0, 4, 0, 4'b0100, 0, 0, 0});
    tv.push_back('{0, 1, 1, 2, 4, 0, 4'b0100, 0, 0, 0});
    tv.push_back('{0, 1, 0, 0, 4, 0, 4'b0000, 0, 0, 0});
    tv.push_back('{0, 1, 0, 0, 4, 0, 4'b0000, 0, 1, 0});
    tv.push_back('{0, 0, 0, 0, 4, 0, 4'b0000, 1, 0, 0});
    tv.push_back('{0, 0, 1, 3, 4, 0, 4'b0000, 1, 0, 0});
    tv.push_back('{0, 0, 0, 0, 4, 0, 4'b0000, 1, 0, 1});
    tv.push_back('{0, 1, 0, 0, 4, 0, 4'b0000, 1, 0, 1});
    tv.push_back('{0, 0, 1, 3, 4, 0, 4'b0001, 1, 0, 1});
    tv.push_back('{0, 0, 0, 0, 4, 0, 4'b0001, 1, 0, 1});
    tv.push_back('{0, 1, 0, 0, 4, 0, 4'b0001, 1, 0, 1});
    tv.push_back('{0, 1, 0, 0, 4, 0, 4'b0011, 1, 0, 1});
    tv.push_back('{0, 0, 0, 0, 4, 1, 4'b0111, 1, 0, 1});
    tv.push_back('{0, 0, 0, 0, 4, 0, 4'b0111, 0, 0, 1});
    tv.push_back('{1, 0, 0, 0, 4, 0, 4'b0111, 0, 0, 1});
    tv.push_back('{0, 0, 0, 0, 4, 0, 4'b0000, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 4, 0, 4'b0000, 1, 0, 0});
    tv.push_back('{0, 0, 0, 0, 4, 0, 4'b0000, 1, 0, 0});
    foreach (tv[k]) begin
      drive(tv[k].r, tv[k].av, tv[k].fv, tv[k].fi, tv[k].mx, tv[k].fl);
      chk($sformatf("vec%0d.slots_busy", k), int'(slots_busy), tv[k].e_busy);
      chk($sformatf("vec%0d.alloc_ready", k), int'(alloc_ready), int'(tv[k].e_rdy));
      chk($sformatf("vec%0d.flush_done", k), int'(flush_done), int'(tv[k].e_done));
      chk($sformatf("vec%0d.err", k), int'(err_double_free), int'(tv[k].e_err));
      advance();
    end
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 3,
            $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 19) == 0);
      advance();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
